// File: rtl/apb_master_pkg.sv
// apb_master_pkg: shared FSM states, response record and default sizes for the APB master bridge.
package apb_master_pkg;
  localparam int ADDR_W         = 32;
  localparam int DATA_W         = 32;
  localparam int TIMEOUT_CYCLES = 16;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  typedef struct packed {
    logic [DATA_W-1:0] rdata;
    logic              error;
    logic              timeout;
  } rsp_t;
endpackage

// File: rtl/apb_master_timeout.sv
// apb_master_timeout: counts PREADY=0 cycles in ACCESS and flags when the wait limit is reached.
module apb_master_timeout
  import apb_master_pkg::*;
#(
  parameter int LIMIT = TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic wait_cycle,
  output logic expired
);
  logic [7:0] r_cnt;
  always_ff @(posedge clk)
    if (rst || start) r_cnt <= '0;
    else if (wait_cycle) r_cnt <= r_cnt + 8'd1;
  assign expired = r_cnt == 8'(LIMIT);
endmodule

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: valid/ready command stream to APB master with a one-entry response slot.
// Optional ACCESS wait timeout is compiled in with APB_MASTER_TIMEOUT_EN.
module apb_master_bridge
  import apb_master_pkg::*;
#(
  parameter int ADDR_W         = apb_master_pkg::ADDR_W,
  parameter int DATA_W         = apb_master_pkg::DATA_W,
  parameter int TIMEOUT_CYCLES = apb_master_pkg::TIMEOUT_CYCLES
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_error,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] PADDR,
  output logic              PWRITE,
  output logic              PSEL,
  output logic              PENABLE,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERROR
);
  state_t            r_state, w_next;
  rsp_t              r_rsp;
  logic              r_rsp_valid, r_psel, r_penable, r_pwrite;
  logic [ADDR_W-1:0] r_paddr;
  logic [DATA_W-1:0] r_pwdata;
  logic              w_done, w_abort, w_accept;
  assign w_done = r_state == ACCESS && PREADY;
`ifdef APB_MASTER_TIMEOUT_EN
  logic w_expired;
  apb_master_timeout #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
    .clk       (PCLK),
    .rst       (PRESET),
    .start     (r_state == SETUP),
    .wait_cycle(r_state == ACCESS && !PREADY),
    .expired   (w_expired)
  );
  assign w_abort = r_state == ACCESS && !PREADY && w_expired;
`else
  logic [7:0] w_unused_timeout;
  assign w_unused_timeout = 8'(TIMEOUT_CYCLES);
  assign w_abort = 1'b0;
`endif
  // abort only happens with PREADY=0, so w_done already keeps cmd_ready low then
  assign cmd_ready = !PRESET && (!r_rsp_valid || rsp_ready) && (r_state == IDLE || w_done);
  assign w_accept  = cmd_valid && cmd_ready;
  always_ff @(posedge PCLK)
    r_state <= PRESET ? IDLE : w_next;
  always_comb begin
    w_next = r_state;
    w_next = w_accept ? SETUP : r_state == SETUP ? ACCESS : (w_done || w_abort) ? IDLE : r_state;
  end
  always_ff @(posedge PCLK)
    if (PRESET) begin
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp       <= '0;
    end else begin
      r_psel    <= w_next != IDLE;
      r_penable <= w_next == ACCESS;
      if (w_accept) begin
        r_paddr  <= cmd_addr;
        r_pwrite <= cmd_write;
        r_pwdata <= cmd_write ? cmd_wdata : '0;
      end
      if (w_done || w_abort) begin
        r_rsp_valid <= 1'b1;
        r_rsp       <= w_abort ? '{rdata: '0, error: 1'b1, timeout: 1'b1}
                               : '{rdata: r_pwrite ? '0 : PRDATA, error: PSLVERROR, timeout: 1'b0};
      end else if (rsp_ready) r_rsp_valid <= 1'b0;
    end
  assign PSEL        = r_psel;
  assign PENABLE     = r_penable;
  assign PWRITE      = r_pwrite;
  assign PADDR       = r_paddr;
  assign PWDATA      = r_pwdata;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp.rdata;
  assign rsp_error   = r_rsp.error;
  assign rsp_timeout = r_rsp.timeout;
endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: directed stimulus with a transaction-level reference model checked every cycle.
module tb_apb_master_bridge;
  localparam int TO = 4;
  logic        PCLK = 0, PRESET = 1, cmd_valid = 0, cmd_write = 0, rsp_ready = 1;
  logic        PREADY = 0, PSLVERROR = 0;
  logic [31:0] cmd_addr = 0, cmd_wdata = 0, PRDATA = 0;
  logic        cmd_ready, rsp_valid, rsp_error, rsp_timeout, PWRITE, PSEL, PENABLE;
  logic [31:0] rsp_rdata, PADDR, PWDATA;
  int errors = 0, checks = 0;

  apb_master_bridge #(.TIMEOUT_CYCLES(TO)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error), .rsp_timeout(rsp_timeout), .PADDR(PADDR), .PWRITE(PWRITE),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERROR(PSLVERROR)
  );

  always #5 PCLK = ~PCLK;

  // model: the in-flight transfer (age = cycles since accept), last bus values, response slot
  bit          m_busy = 0, m_rv = 0, m_err = 0, m_to = 0, m_pwrite = 0;
  int          m_age = 0, m_waits = 0;
  logic [31:0] m_paddr = 0, m_pwdata = 0, m_rdata = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    bit exp_ready, done, abort, acc;
    @(negedge PCLK);
    exp_ready = !PRESET && (!m_rv || rsp_ready) && (!m_busy || (m_age >= 1 && PREADY));
    chkb("PSEL", PSEL, m_busy);
    chkb("PENABLE", PENABLE, m_busy && m_age >= 1);
    chk("PADDR", PADDR, m_paddr);
    chkb("PWRITE", PWRITE, m_pwrite);
    chk("PWDATA", PWDATA, m_pwdata);
    chkb("cmd_ready", cmd_ready, exp_ready);
    chkb("rsp_valid", rsp_valid, m_rv);
    if (m_rv) begin
      chk("rsp_rdata", rsp_rdata, m_rdata);
      chkb("rsp_error", rsp_error, m_err);
      chkb("rsp_timeout", rsp_timeout, m_to);
    end
    if (PRESET) begin
      m_busy = 0; m_rv = 0; m_err = 0; m_to = 0; m_pwrite = 0;
      m_age = 0; m_waits = 0; m_paddr = 0; m_pwdata = 0; m_rdata = 0;
    end else begin
      acc   = cmd_valid && exp_ready;
      done  = m_busy && m_age >= 1 && PREADY;
      abort = 0;
`ifdef APB_MASTER_TIMEOUT_EN
      abort = m_busy && m_age >= 1 && !PREADY && m_waits == TO;
`endif
      if (m_rv && rsp_ready) m_rv = 0;
      if (done || abort) begin
        m_rv = 1;
        m_rdata = (done && !m_pwrite) ? PRDATA : 32'h0;
        m_err = abort ? 1'b1 : PSLVERROR;
        m_to = abort;
        m_busy = 0;
      end else if (m_busy) begin
        if (m_age >= 1 && !PREADY) m_waits++;
        m_age++;
      end
      if (acc) begin
        m_busy = 1; m_age = 0; m_waits = 0;
        m_paddr = cmd_addr; m_pwrite = cmd_write; m_pwdata = cmd_write ? cmd_wdata : 32'h0;
      end
    end
    @(posedge PCLK);
    #1;
  endtask

  // one isolated transfer from an idle bus; PREADY low for `waits` ACCESS cycles
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] rdata, input int waits, input logic err);
    int ps = 0, pe = 0, lat = 0;
    cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
    PRDATA = rdata; PSLVERROR = err; PREADY = 0;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      tick();
      if (k == 1) cmd_valid = 0;
      ps += int'(PSEL);
      pe += int'(PENABLE);
      if (k == 2 + waits) PREADY = 1;
      if (rsp_valid) lat = k;
    end
    chk("xfer_latency", lat, 3 + waits);
    chk("xfer_psel_cycles", ps, 2 + waits);
    chk("xfer_penable_cycles", pe, 1 + waits);
    chk("xfer_rdata", rsp_rdata, wr ? 32'h0 : rdata);
    chkb("xfer_error", rsp_error, err);
    chkb("xfer_timeout", rsp_timeout, 1'b0);
    PREADY = 0; PSLVERROR = 0;
  endtask

  initial begin
    logic [3:0] psel_pat, pen_pat;
    int lat;
    tick(); tick();
    chkb("reset_psel", PSEL, 1'b0);
    chk("reset_paddr", PADDR, 32'h0);
    chkb("reset_rsp_valid", rsp_valid, 1'b0);
    chkb("reset_cmd_ready", cmd_ready, 1'b0);
    PRESET = 0;
    #1 chkb("post_reset_cmd_ready", cmd_ready, 1'b1);
    tick();

    xfer(1'b0, 32'h0000_0040, 32'h0, 32'hDEAD_BEEF, 0, 1'b0);
    tick();
    xfer(1'b1, 32'h0000_0010, 32'h1234_5678, 32'hFFFF_FFFF, 3, 1'b0);
    tick();

    // back-to-back read then write with cmd_valid held
    PREADY = 1; PRDATA = 32'hA5A5_A5A5;
    cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h20;
    tick();
    psel_pat[3] = PSEL; pen_pat[3] = PENABLE;
    cmd_write = 1; cmd_addr = 32'h24; cmd_wdata = 32'h0BAD_F00D;
    tick();
    psel_pat[2] = PSEL; pen_pat[2] = PENABLE;
    tick();
    psel_pat[1] = PSEL; pen_pat[1] = PENABLE;
    chkb("b2b_rsp1_valid", rsp_valid, 1'b1);
    chk("b2b_rsp1_rdata", rsp_rdata, 32'hA5A5_A5A5);
    chkb("b2b_pwrite_switch", PWRITE, 1'b1);
    cmd_valid = 0;
    tick();
    psel_pat[0] = PSEL; pen_pat[0] = PENABLE;
    tick();
    chk("b2b_psel_pattern", 32'(psel_pat), 32'hF);
    chk("b2b_penable_pattern", 32'(pen_pat), 32'h5);
    chkb("b2b_rsp2_valid", rsp_valid, 1'b1);
    chk("b2b_rsp2_rdata", rsp_rdata, 32'h0);
    chkb("b2b_idle_after", PSEL, 1'b0);
    PREADY = 0;
    tick();

    xfer(1'b0, 32'h30, 32'h0, 32'h5555_0001, 0, 1'b1);
    xfer(1'b0, 32'h34, 32'h0, 32'h5555_0002, 1, 1'b0);
    tick();

    // response held: no new SETUP until rsp_ready returns
    rsp_ready = 0;
    xfer(1'b0, 32'h70, 32'h0, 32'h7777_0007, 0, 1'b0);
    cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h80; PRDATA = 32'h8888_0008;
    #1 chkb("held_cmd_ready", cmd_ready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chkb("held_no_setup", PSEL, 1'b0);
      chkb("held_rsp_valid", rsp_valid, 1'b1);
    end
    rsp_ready = 1;
    #1 chkb("released_cmd_ready", cmd_ready, 1'b1);
    tick();
    chkb("released_setup", PSEL, 1'b1);
    cmd_valid = 0; PREADY = 1;
    tick(); tick();
    chk("released_rdata", rsp_rdata, 32'h8888_0008);
    PREADY = 0;
    tick();

`ifdef APB_MASTER_TIMEOUT_EN
    cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h90; PREADY = 0;
    lat = 0;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      tick();
      if (k == 1) cmd_valid = 0;
      if (rsp_valid) lat = k;
    end
    chk("timeout_latency", lat, 3 + TO);
    chkb("timeout_error", rsp_error, 1'b1);
    chkb("timeout_flag", rsp_timeout, 1'b1);
    chk("timeout_rdata", rsp_rdata, 32'h0);
    chkb("timeout_psel", PSEL, 1'b0);
    tick();
    xfer(1'b0, 32'h94, 32'h0, 32'h9999_0009, TO, 1'b0);
    tick();
`endif

    // reset mid-ACCESS drops the bus and loses the transfer
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'hA0; cmd_wdata = 32'hCAFE_0001; PREADY = 0;
    tick();
    cmd_valid = 0;
    tick(); tick();
    chkb("pre_reset_penable", PENABLE, 1'b1);
    PRESET = 1;
    #1 chkb("in_reset_cmd_ready", cmd_ready, 1'b0);
    tick();
    chkb("mid_reset_psel", PSEL, 1'b0);
    chkb("mid_reset_rsp_valid", rsp_valid, 1'b0);
    chk("mid_reset_pwdata", PWDATA, 32'h0);
    PRESET = 0; PREADY = 1;
    #1 chkb("after_reset_cmd_ready", cmd_ready, 1'b1);
    tick(); tick();
    chkb("after_reset_no_rsp", rsp_valid, 1'b0);
    PREADY = 0;
    xfer(1'b0, 32'hB0, 32'h0, 32'h0123_4567, 2, 1'b0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/apb_master_bridge.md
# apb_master_bridge

Converts a simple valid/ready command stream into APB transfers, driving PADDR/PWRITE/PSEL/PENABLE/PWDATA. It returns each completion (read data or error) on a one-entry response port. It sits directly upstream of the APB bus protocol checker and any APB slaves. It produces exactly the SETUP → ACCESS → (optional wait) → completion sequence that the checker's IDLE/ENABLE/STANDBY states accept, including back-to-back transfers with PSEL held high.

## Interface
- ADDR_W, 32, PADDR and cmd_addr width
- DATA_W, 32, PWDATA/PRDATA/cmd_wdata/rsp_rdata width
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles with PREADY=0 before abort; legal range 1..255; used only when the timeout feature is compiled in
- PCLK  in  1  sole clock; all logic on rising edge
- PRESET  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  transfer address
- cmd_wdata  in  DATA_W  write data; ignored for reads
- rsp_valid  out  1  response held until rsp_ready
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
- rsp_rdata  out  DATA_W  PRDATA captured on read completion; 0 for writes and aborts
- rsp_error  out  1  PSLVERROR captured at completion, or timeout abort
- rsp_timeout  out  1  set with rsp_error when the abort was caused by timeout
- PADDR  out  ADDR_W  registered
- PWRITE  out  1  registered
- PSEL  out  1  registered
- PENABLE  out  1  registered
- PWDATA  out  DATA_W  registered; 0 during reads
- PRDATA  in  DATA_W  slave read data
- PREADY  in  1  slave ready
- PSLVERROR  in  1  slave error; valid only when PREADY=1 in ACCESS

## Operation
- **States**
  - IDLE: PSEL=0, PENABLE=0.
  - SETUP: PSEL=1, PENABLE=0; lasts exactly one cycle, then ACCESS.
  - ACCESS: PSEL=1, PENABLE=1.
- **cmd_ready rule.** cmd_ready = (!rsp_valid || rsp_ready) && (state==IDLE || (state==ACCESS && PREADY)), with abort excluded as described below. It is combinational from state, rsp_valid, rsp_ready and PREADY.
- **Accept in IDLE.** Latch cmd_addr/cmd_write/cmd_wdata into the P* registers; next state SETUP.
- **ACCESS with PREADY=0.** Hold all P* outputs stable.
- **ACCESS with PREADY=1 (completion).**
  - Load the response register: rdata = PWRITE ? 0 : PRDATA; error = PSLVERROR; timeout = 0; rsp_valid set.
  - If a command is accepted in the same cycle, go to SETUP with PSEL kept at 1, PENABLE=0, and the new P* values.
  - Otherwise go to IDLE: PSEL=0, PENABLE=0. PADDR/PWRITE/PWDATA keep their last values.
- **Response slot.** The single response register is cleared on rsp_ready and may be reloaded in the same cycle. A new command is never issued unless the slot will be free at its completion.
- **Direction switch.** Read and write may be issued back-to-back in either order. PWRITE changes only at entry to SETUP.
- **Reset.** PRESET overrides everything, including mid-transfer. The bus drops immediately (PSEL=0 on the next edge), no response is produced, and the in-flight command is lost.

## Timing
- Command accepted at edge N → SETUP visible after edge N, ACCESS after edge N+1.
- With zero wait states: completion sampled at edge N+2, rsp_valid high after edge N+2. Latency is 3 cycles from accept to response.
- Each PREADY=0 cycle in ACCESS adds one cycle.
- Back-to-back sustained throughput is one transfer per 2 cycles. There is no IDLE cycle between transfers.
- Reset values: PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_error=0, rsp_timeout=0. cmd_ready is 0 during reset and 1 in the first cycle after reset.

## Configuration
- Macro: APB_MASTER_TIMEOUT_EN.
- **Defined**
  - An 8-bit counter clears on entry to ACCESS and increments on each ACCESS cycle with PREADY=0.
  - When the count equals TIMEOUT_CYCLES and PREADY is still 0, the transfer aborts. Next state is IDLE with PSEL=0, PENABLE=0.
  - The abort loads a response with rdata=0, error=1, timeout=1.
  - cmd_ready=0 in the abort cycle.
  - PREADY=1 in the same cycle as the count reaching the limit wins: normal completion.
- **Not defined**
  - No counter exists and rsp_timeout is tied to 0.
  - ACCESS waits indefinitely.

## Structure
- Package apb_master_pkg:
  - state enum (IDLE, SETUP, ACCESS);
  - response struct (rdata, error, timeout);
  - default constants ADDR_W/DATA_W/TIMEOUT_CYCLES.
- Sub-module apb_master_timeout: the wait counter, exposing inputs start and wait_cycle and output expired. It is instantiated only under APB_MASTER_TIMEOUT_EN.

## Test plan
- Single read to 0x0000_0040, PREADY=1, PRDATA=0xDEAD_BEEF → PSEL high 2 cycles, PENABLE high 1 cycle; rsp_valid 3 cycles after accept with rdata=0xDEAD_BEEF, error=0.
- Write 0x1234_5678 to 0x10, PREADY held low 3 ACCESS cycles → P* signals stable throughout; response after 6 cycles with rdata=0, error=0.
- Read then write back-to-back with cmd_valid held → PSEL stays 1 across both; PENABLE pattern 0,1,0,1; two responses in order.
- Read with PREADY=1, PSLVERROR=1 → rsp_error=1, rsp_timeout=0; a following command proceeds normally.
- rsp_ready=0 with response pending and a new command presented → cmd_ready=0 and no SETUP until rsp_ready=1.
- With APB_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=4, PREADY stuck 0 → abort after 4 wait cycles with error=1, timeout=1, PSEL=0. Assert PRESET mid-ACCESS in a second run → PSEL=0 next cycle and no response.
